// File: rtl/fifo_read_arbiter.sv
// Round-robin arbiter sharing one FIFO read port among INT_REQ_CNT consumers, bursts of up to INT_BURST_LEN words.
// Latency: grant registered one cycle after request; valid/data/pop are combinational while granted.
// Backpressure: pop only when the granted consumer requests and is ready; FIFO_RD_ARB_WORD_CNT_EN adds o_word_cnt.
module fifo_read_arbiter #(
  parameter int INT_REQ_CNT   = 4,
  parameter int INT_BURST_LEN = 8,
  parameter int INT_DATA_BITS = 32
) (
  input  logic                     rd_clk,
  input  logic                     rd_rst,
  input  logic                     i_fifo_valid,
  input  logic [INT_DATA_BITS-1:0] i_fifo_data,
  output logic                     o_fifo_dready,
  input  logic [INT_REQ_CNT-1:0]   i_req,
  input  logic [INT_REQ_CNT-1:0]   i_cons_dready,
  output logic [INT_REQ_CNT-1:0]   o_cons_valid,
  output logic [INT_DATA_BITS-1:0] o_cons_data,
  output logic [INT_REQ_CNT-1:0]   o_grant,
  output logic                     o_busy
`ifdef FIFO_RD_ARB_WORD_CNT_EN
  ,
  output logic [31:0]              o_word_cnt
`endif
);

  localparam int PTR_W = (INT_REQ_CNT > 1) ? $clog2(INT_REQ_CNT) : 1;
  localparam int CNT_W = (INT_BURST_LEN > 1) ? $clog2(INT_BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(INT_BURST_LEN - 1);
  localparam logic [PTR_W-1:0] PTR_RST   = PTR_W'(INT_REQ_CNT - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  state_t                 state_q;
  logic [INT_REQ_CNT-1:0] grant_q;
  logic                   busy_q;
  logic [CNT_W-1:0]       beat_q;
  logic [PTR_W-1:0]       last_q;

  logic [PTR_W-1:0]       sel_d;
  logic                   sel_vld_d;
  logic [INT_REQ_CNT-1:0] sel_onehot_d;
  logic                   req_g;
  logic                   rdy_g;
  logic                   in_xfer;
  logic                   xfer;

  // Round-robin pick: first requester searching upward from last_q+1 with wrap
  always_comb begin
    sel_d        = last_q;
    sel_vld_d    = 1'b0;
    sel_onehot_d = '0;
    // Walk offsets downward so the smallest offset is the last (winning) assignment
    for (int i = INT_REQ_CNT; i >= 1; i--) begin
      if (i_req[(int'(last_q) + i) % INT_REQ_CNT]) begin
        sel_d     = PTR_W'((int'(last_q) + i) % INT_REQ_CNT);
        sel_vld_d = 1'b1;
      end
    end
    sel_onehot_d[sel_d] = sel_vld_d;
  end

  // During XFER last_q always holds the granted index
  assign req_g   = i_req[last_q];
  assign rdy_g   = i_cons_dready[last_q];
  assign in_xfer = (state_q == ST_XFER) && !rd_rst;

  // Pop only when a word is actually there, so an empty FIFO never sees a strobe
  assign o_fifo_dready = in_xfer & req_g & rdy_g & i_fifo_valid;
  assign xfer          = o_fifo_dready;
  assign o_cons_data   = i_fifo_data;
  assign o_grant       = grant_q;
  assign o_busy        = busy_q;

  // Steer valid to the granted consumer only; grant_q is one-hot in XFER
  always_comb begin
    o_cons_valid = '0;
    if (in_xfer) begin
      o_cons_valid = grant_q & {INT_REQ_CNT{i_fifo_valid & req_g}};
    end
  end

  // Arbitration FSM: grant in IDLE, hold in XFER until burst end or request drop
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      busy_q  <= 1'b0;
      beat_q  <= '0;
      last_q  <= PTR_RST;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sel_vld_d) begin
            state_q <= ST_XFER;
            grant_q <= sel_onehot_d;
            busy_q  <= 1'b1;
            beat_q  <= '0;
            last_q  <= sel_d;
          end
        end
        ST_XFER: begin
          if (!req_g || (xfer && (beat_q == LAST_BEAT))) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
          end
          if (xfer) begin
            beat_q <= beat_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIFO_RD_ARB_WORD_CNT_EN
  logic [31:0] word_cnt_q;

  // Free-running count of delivered words, wraps naturally
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      word_cnt_q <= '0;
    end else if (xfer) begin
      word_cnt_q <= word_cnt_q + 32'd1;
    end
  end

  assign o_word_cnt = word_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Directed bench for fifo_read_arbiter with a counting FIFO model and grant-segment tracking.
// Latency: inputs change 1 time unit after the rising edge; outputs sampled on the falling edge.
// Backpressure: the FIFO model pops whenever o_fifo_dready and i_fifo_valid are both high.
module tb_fifo_read_arbiter;
  localparam int N  = 4;
  localparam int BL = 8;
  localparam int DW = 32;

  logic          rd_clk = 1'b0;
  logic          rd_rst;
  logic          i_fifo_valid;
  logic [DW-1:0] i_fifo_data;
  logic          o_fifo_dready;
  logic [N-1:0]  i_req;
  logic [N-1:0]  i_cons_dready;
  logic [N-1:0]  o_cons_valid;
  logic [DW-1:0] o_cons_data;
  logic [N-1:0]  o_grant;
  logic          o_busy;
`ifdef FIFO_RD_ARB_WORD_CNT_EN
  logic [31:0]   o_word_cnt;
`endif

  fifo_read_arbiter #(
    .INT_REQ_CNT  (N),
    .INT_BURST_LEN(BL),
    .INT_DATA_BITS(DW)
  ) dut (
    .rd_clk       (rd_clk),
    .rd_rst       (rd_rst),
    .i_fifo_valid (i_fifo_valid),
    .i_fifo_data  (i_fifo_data),
    .o_fifo_dready(o_fifo_dready),
    .i_req        (i_req),
    .i_cons_dready(i_cons_dready),
    .o_cons_valid (o_cons_valid),
    .o_cons_data  (o_cons_data),
    .o_grant      (o_grant),
    .o_busy       (o_busy)
`ifdef FIFO_RD_ARB_WORD_CNT_EN
    ,
    .o_word_cnt   (o_word_cnt)
`endif
  );

  always #5 rd_clk = ~rd_clk;

  // FIFO model: occupancy count and an incrementing head word
  int            fifo_cnt;
  logic [DW-1:0] next_word;
  assign i_fifo_valid = (fifo_cnt > 0);
  assign i_fifo_data  = next_word;

  int checks;
  int failures;
  int inv_err;
  int cyc;
  int pop_total;
  int dready_cnt;
  int idle_run;
  int seg_n;
  logic [N-1:0] seg_grant [16];
  int           seg_cnt   [16];
  int           seg_gap   [16];
  int           seg_start [16];
  logic [N-1:0] prev_grant;
  logic [N-1:0] obs_grant;
  logic [N-1:0] obs_valid;
  logic         obs_dready;
  logic         obs_busy;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: sample at falling edge, then advance the FIFO model after the rising edge
  task automatic tick();
    logic [N-1:0] ev;
    logic         ed;
    logic         pop;
    @(negedge rd_clk);
    obs_grant  = o_grant;
    obs_valid  = o_cons_valid;
    obs_dready = o_fifo_dready;
    obs_busy   = o_busy;
    ev  = rd_rst ? '0 : (o_grant & i_req & {N{i_fifo_valid}});
    ed  = !rd_rst && i_fifo_valid && ((o_grant & i_req & i_cons_dready) != '0);
    if (o_cons_valid !== ev) inv_err++;
    if (o_fifo_dready !== ed) inv_err++;
    if (o_busy !== (o_grant != '0)) inv_err++;
    if ($countones(o_grant) > 1) inv_err++;
    if (o_cons_data !== i_fifo_data) inv_err++;
    pop = o_fifo_dready && i_fifo_valid;
    if (o_fifo_dready) dready_cnt++;
    if ((o_grant != '0) && (prev_grant == '0) && (seg_n < 16)) begin
      seg_grant[seg_n] = o_grant;
      seg_cnt[seg_n]   = 0;
      seg_gap[seg_n]   = idle_run;
      seg_start[seg_n] = cyc;
      seg_n++;
    end
    if (o_grant == '0) idle_run++;
    else idle_run = 0;
    if (pop && (seg_n > 0)) seg_cnt[seg_n-1]++;
    if (pop) pop_total++;
    prev_grant = o_grant;
    cyc++;
    @(posedge rd_clk);
    #1;
    if (pop) begin
      fifo_cnt--;
      next_word++;
    end
  endtask

  task automatic do_reset();
    rd_rst        = 1'b1;
    i_req         = '0;
    i_cons_dready = '1;
    fifo_cnt      = 0;
    repeat (2) tick();
    rd_rst     = 1'b0;
    seg_n      = 0;
    cyc        = 0;
    idle_run   = 0;
    pop_total  = 0;
    dready_cnt = 0;
    prev_grant = '0;
  endtask

  initial begin
    logic [N-1:0] exp_g [5];
    checks     = 0;
    failures   = 0;
    inv_err    = 0;
    next_word  = 32'h1000;
    rd_rst     = 1'b1;
    i_req      = '0;
    i_cons_dready = '1;
    fifo_cnt   = 0;
    prev_grant = '0;
    seg_n      = 0;
    cyc        = 0;
    idle_run   = 0;

    // Reset state
    do_reset();
    tick();
    check_eq("rst_grant",  64'(obs_grant),  64'(0));
    check_eq("rst_busy",   64'(obs_busy),   64'(0));
    check_eq("rst_dready", 64'(obs_dready), 64'(0));
    check_eq("rst_valid",  64'(obs_valid),  64'(0));

    // Two requesters, 20 words: 8 to c0, 8 to c2, 4 to c0
    do_reset();
    i_req    = 4'b0101;
    fifo_cnt = 20;
    repeat (40) tick();
    check_eq("r30_segs",   64'(seg_n),        64'(3));
    check_eq("r30_g0",     64'(seg_grant[0]), 64'(4'b0001));
    check_eq("r30_n0",     64'(seg_cnt[0]),   64'(8));
    check_eq("r30_g1",     64'(seg_grant[1]), 64'(4'b0100));
    check_eq("r30_n1",     64'(seg_cnt[1]),   64'(8));
    check_eq("r30_g2",     64'(seg_grant[2]), 64'(4'b0001));
    check_eq("r30_n2",     64'(seg_cnt[2]),   64'(4));
    check_eq("r30_gap1",   64'(seg_gap[1]),   64'(1));
    check_eq("r30_gap2",   64'(seg_gap[2]),   64'(1));
    check_eq("r30_first",  64'(seg_start[0]), 64'(1));
    check_eq("r30_pops",   64'(pop_total),    64'(20));

    // All four requesting: full rotation, 8 beats each
    do_reset();
    i_req    = 4'b1111;
    fifo_cnt = 1000;
    repeat (46) tick();
    exp_g[0] = 4'b0001;
    exp_g[1] = 4'b0010;
    exp_g[2] = 4'b0100;
    exp_g[3] = 4'b1000;
    exp_g[4] = 4'b0001;
    check_eq("r31_segs", 64'(seg_n), 64'(5));
    for (int k = 0; k < 5; k++) begin
      check_eq($sformatf("r31_g%0d", k), 64'(seg_grant[k]), 64'(exp_g[k]));
      check_eq($sformatf("r31_n%0d", k), 64'(seg_cnt[k]),   64'(8));
    end

    // Request drop mid-burst on consumer 1
    do_reset();
    i_req    = 4'b0010;
    fifo_cnt = 1000;
    repeat (4) tick();
    i_req = 4'b1001;
    tick();
    check_eq("r32_dready", 64'(obs_dready), 64'(0));
    check_eq("r32_valid",  64'(obs_valid),  64'(0));
    check_eq("r32_held",   64'(obs_grant),  64'(4'b0010));
    check_eq("r32_pops",   64'(pop_total),  64'(3));
    tick();
    check_eq("r32_idle",   64'(obs_grant),  64'(0));
    check_eq("r32_ibusy",  64'(obs_busy),   64'(0));
    tick();
    check_eq("r32_next",   64'(obs_grant),  64'(4'b1000));

    // Empty FIFO: grant held, no strobe, then two words delivered
    do_reset();
    i_req    = 4'b0001;
    fifo_cnt = 0;
    tick();
    repeat (50) tick();
    check_eq("r33_grant",  64'(obs_grant),  64'(4'b0001));
    check_eq("r33_busy",   64'(obs_busy),   64'(1));
    check_eq("r33_nostrb", 64'(dready_cnt), 64'(0));
    fifo_cnt = 2;
    repeat (4) tick();
    check_eq("r33_pops",   64'(pop_total),  64'(2));
    check_eq("r33_hold2",  64'(obs_grant),  64'(4'b0001));
    check_eq("r33_fifo",   64'(fifo_cnt),   64'(0));

    // Reset mid-burst after 5 transfers
    do_reset();
    i_req    = 4'b0011;
    fifo_cnt = 1000;
    repeat (6) tick();
    check_eq("r34_pops", 64'(pop_total), 64'(5));
    rd_rst = 1'b1;
    tick();
    check_eq("r34_rstdr", 64'(obs_dready), 64'(0));
    check_eq("r34_pops2", 64'(pop_total),  64'(5));
    rd_rst = 1'b0;
    tick();
    check_eq("r34_grant", 64'(obs_grant), 64'(0));
    check_eq("r34_busy",  64'(obs_busy),  64'(0));
    tick();
    check_eq("r34_c0",    64'(obs_grant), 64'(4'b0001));

`ifdef FIFO_RD_ARB_WORD_CNT_EN
    // Word counter wrap from a preloaded value
    do_reset();
    check_eq("r35_rst", 64'(o_word_cnt), 64'(0));
    force dut.word_cnt_q = 32'hFFFF_FFFE;
    #2;
    release dut.word_cnt_q;
    i_req    = 4'b0001;
    fifo_cnt = 3;
    repeat (6) tick();
    check_eq("r35_wrap", 64'(o_word_cnt), 64'(32'h0000_0001));
`endif

    check_eq("invariants", 64'(inv_err), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
